prio_scan: RTL and testbench
============================

# prio_scan

Sequential, parametrised priority scanner: accepts a request word over a valid/ready handshake and emits the index of every set bit, one per output beat, in priority order. It is the successor to the combinational `casez` leading-one decoders in the diagnostic set. It adds configurable width, selectable scan direction, explicit all-zero reporting, last-beat marking and backpressure. It sits between a request-vector producer and any index consumer (arbiter grant logic, instruction pre-decode).

## Interface
- `WIDTH`, 8: request word width; legal range is ≥2.
- `MSB_FIRST`, 1:
  - 1: highest set bit is emitted first.
  - 0: lowest set bit is emitted first.
- `IDX_W`, derived as `$clog2(WIDTH)`: index width. Not overridable.

Ports:
- `clk`  in  1  the single clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  request word presented.
- `in_ready`  out  1  block can take a word this cycle.
- `in_data`  in  WIDTH  request word; treated as 2-state.
- `out_valid`  out  1  index beat presented.
- `out_ready`  in  1  consumer takes the beat this cycle.
- `out_idx`  out  IDX_W  bit position of the current beat.
- `out_last`  out  1  final beat of the current word.
- `out_zero`  out  1  accepted word was all zero.

## Operation
- Registers:
  - `state` (IDLE/SCAN).
  - `mask` (WIDTH bits): remaining unreported bits.
  - `zero_r`: word was zero.
- IDLE:
  - `out_valid`=0, `in_ready`=1.
  - On `in_valid & in_ready`: `mask`←`in_data`, `zero_r`←(`in_data`==0), go to SCAN.
- SCAN:
  - `out_valid`=1.
  - `out_idx` = priority-encoded position of `mask` in the configured direction.
  - `out_last` = `zero_r` | (`mask` has exactly one bit set).
  - `out_zero` = `zero_r`.
- Beat transfer (`out_valid & out_ready`):
  - Not last: clear bit `out_idx` in `mask`, stay in SCAN.
  - Last: return to IDLE, unless a new word is accepted in the same cycle (see below).
- All-zero word produces exactly one beat: `out_idx`=0, `out_zero`=1, `out_last`=1.
- Back-to-back input:
  - In SCAN, `in_ready` = `out_last & out_ready` (combinational path from `out_ready`).
  - On that cycle a new word is loaded and the block stays in SCAN, so no bubble.
- Hold while stalled: while `out_valid & !out_ready`, `out_idx`, `out_last` and `out_zero` stay constant. `mask` is not modified.
- Zeroing of outputs:
  - `out_idx` and `out_zero` are driven 0 when `out_valid`=0.
  - `out_last` is 0 when `out_valid`=0.
- A word with k set bits occupies max(k,1) beats.

## Timing
- Reset (`rst_n` low, asynchronous):
  - `state`=IDLE, `mask`=0, `zero_r`=0.
  - Outputs: `out_valid`=0, `out_idx`=0, `out_last`=0, `out_zero`=0, `in_ready`=1.
- Reset mid-scan discards the remaining bits; no further beats for that word.
- Latency: the first beat is valid in the cycle after input acceptance (1 cycle). Subsequent beats follow each accepted beat with zero bubbles.
- `in_valid` is ignored while `in_ready`=0. Producer holds the word until accepted.
- `out_valid` never drops without a transfer, except on reset.

## Structure
- Shared package/include `prio_scan_pkg` holds:
  - state encodings: IDLE=1'b0, SCAN=1'b1;
  - the index-width helper function.
- Sub-module `prio_enc`: combinational leading-one encoder.
  - Parameters: `WIDTH`, `MSB_FIRST`.
  - Outputs: `idx` and `any`.
  - Used once on `mask`.
- Top contains only the FSM, the `mask` clear logic, the one-hot check for `out_last`, and the handshake.

## Test plan
- WIDTH=8, MSB_FIRST=1, `out_ready`=1. Accept 8'h00 → next cycle one beat: `out_idx`=0, `out_zero`=1, `out_last`=1. Then IDLE, `in_ready`=1.
- Accept 8'h05 → beats `out_idx`=2 (last=0), then 0 (last=1) on consecutive cycles starting 1 cycle after accept.
- Accept 8'hff with `out_ready` toggling 1,0,0,1,… → 8 beats, indices 7 down to 0. Each index held stable across stall cycles. `in_ready`=0 until the beat with idx 0.
- Back-to-back: 8'h80 then 8'h01 with `in_valid` held.
  - Second word accepted in the same cycle as the idx-7 last beat.
  - idx 0 appears the next cycle; no idle cycle between.
- WIDTH=16, MSB_FIRST=0: accept 16'h8001 → beats `out_idx`=0, then 15 (last=1). Stall on the first beat does not change it.
- Reset after the first beat of 8'h0f (idx 3 emitted) → `out_valid`=0 immediately. Then accept 8'h02 → single beat, idx 1, last=1; no stale indices from 8'h0f.

Source files
------------

// File: rtl/prio_scan_pkg.sv
// Shared definitions for the priority scanner: FSM state encoding and index-width helper.
package prio_scan_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Index width for a WIDTH-bit word; never narrower than one bit.
    function automatic int idx_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/prio_enc.sv
// Combinational leading-one encoder: position of the first set bit in the chosen direction.
module prio_enc
    import prio_scan_pkg::*;
#(
    parameter  int WIDTH     = 8,
    parameter  bit MSB_FIRST = 1'b1,
    localparam int IDX_W     = idx_width(WIDTH)
) (
    input  logic [WIDTH-1:0] req,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // NOTE: every output gets a default before the loop, so no latch can be inferred.
    always_comb begin
        idx = '0;
        any = |req;
        // The last match in loop order wins, so scan towards the priority end.
        if (MSB_FIRST) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (req[i]) idx = IDX_W'(i);
            end
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (req[i]) idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/prio_scan.sv
// Sequential priority scanner: takes a request word, emits one index per beat in priority order.
module prio_scan
    import prio_scan_pkg::*;
#(
    parameter  int WIDTH     = 8,
    parameter  bit MSB_FIRST = 1'b1,
    localparam int IDX_W     = idx_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             out_zero
);

    state_t           state;
    logic [WIDTH-1:0] mask;
    logic             zero_r;

    logic [IDX_W-1:0] enc_idx;
    logic             enc_any;
    logic             one_hot;
    logic             accept;
    logic             xfer;

    prio_enc #(
        .WIDTH    (WIDTH),
        .MSB_FIRST(MSB_FIRST)
    ) u_enc (
        .req(mask),
        .idx(enc_idx),
        .any(enc_any)
    );

    assign one_hot   = enc_any && ((mask & (mask - WIDTH'(1))) == '0);

    assign out_valid = (state == SCAN);
    assign out_idx   = (out_valid && !zero_r) ? enc_idx : '0;
    assign out_last  = out_valid && (zero_r || one_hot);
    assign out_zero  = out_valid && zero_r;

    // A new word may enter on the cycle the final beat leaves, giving back-to-back words.
    assign in_ready  = (state == IDLE) || (out_last && out_ready);
    assign accept    = in_valid && in_ready;
    assign xfer      = out_valid && out_ready;

    // NOTE: state registers use non-blocking assignments only, and mask is reset so no stale bits survive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            mask   <= '0;
            zero_r <= 1'b0;
        end else if (accept) begin
            state  <= SCAN;
            mask   <= in_data;
            zero_r <= (in_data == '0);
        end else if (xfer) begin
            mask <= mask & ~(WIDTH'(1) << enc_idx);
            if (out_last) state <= IDLE;
        end
    end

endmodule

// File: tb/tb_prio_scan.sv
// Self-checking bench for prio_scan: table vectors, stall patterns, back-to-back, reset, random words.
module tb_prio_scan;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        in_valid8, in_ready8, out_valid8, out_ready8, out_last8, out_zero8;
    logic [7:0]  in_data8;
    logic [2:0]  out_idx8;

    logic        in_valid16, in_ready16, out_valid16, out_ready16, out_last16, out_zero16;
    logic [15:0] in_data16;
    logic [3:0]  out_idx16;

    prio_scan #(.WIDTH(8), .MSB_FIRST(1'b1)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_idx(out_idx8),
        .out_last(out_last8), .out_zero(out_zero8)
    );

    prio_scan #(.WIDTH(16), .MSB_FIRST(1'b0)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid16), .in_ready(in_ready16), .in_data(in_data16),
        .out_valid(out_valid16), .out_ready(out_ready16), .out_idx(out_idx16),
        .out_last(out_last16), .out_zero(out_zero16)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    typedef struct {
        logic [7:0] data;
        int         beats;
        int         first_idx;
    } vec_t;

    // Present one word to dut8, then follow every beat against a list of set-bit positions.
    // mode 0: out_ready always 1; mode 1: pattern 1,0,0,1,...; mode 2: random.
    task automatic run_word8(input logic [7:0] word, input int mode,
                             output int beats, output int first);
        int         exp_q[$];
        int         cyc;
        logic [2:0] held_idx;
        bit         stalled;
        for (int i = 7; i >= 0; i--) if (word[i]) exp_q.push_back(i);
        if (exp_q.size() == 0) exp_q.push_back(0);
        beats = 0;
        first = -1;
        @(posedge clk); #1;
        in_valid8 = 1'b1;
        in_data8  = word;
        @(negedge clk);
        check("accept_ready", in_ready8, 1);
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        in_data8  = 8'($urandom);
        cyc = 0;
        stalled = 1'b0;
        held_idx = '0;
        while (exp_q.size() > 0 && cyc < 200) begin
            case (mode)
                0:       out_ready8 = 1'b1;
                1:       out_ready8 = (cyc % 3 == 0);
                default: out_ready8 = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            check("beat_valid", out_valid8, 1);
            if (stalled) check("hold_idx", out_idx8, held_idx);
            check("beat_idx", out_idx8, exp_q[0]);
            check("beat_last", out_last8, exp_q.size() == 1);
            check("beat_zero", out_zero8, word == 8'h00);
            check("scan_in_ready", in_ready8, (exp_q.size() == 1) && out_ready8);
            if (first < 0) first = out_idx8;
            held_idx = out_idx8;
            stalled  = !out_ready8;
            if (out_ready8) begin
                void'(exp_q.pop_front());
                beats++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (exp_q.size() > 0) check("beat_timeout", 0, 1);
        out_ready8 = 1'b1;
        @(negedge clk);
        check("idle_valid", out_valid8, 0);
        check("idle_ready", in_ready8, 1);
        check("idle_idx", out_idx8, 0);
    endtask

    initial begin
        vec_t table_v[6];
        int   beats, first;

        table_v[0] = '{8'h00, 1, 0};
        table_v[1] = '{8'h05, 2, 2};
        table_v[2] = '{8'hff, 8, 7};
        table_v[3] = '{8'h80, 1, 7};
        table_v[4] = '{8'h01, 1, 0};
        table_v[5] = '{8'h3c, 4, 5};

        rst_n = 1'b0;
        in_valid8 = 0; in_data8 = 0; out_ready8 = 1;
        in_valid16 = 0; in_data16 = 0; out_ready16 = 1;
        #12;
        check("rst_valid", out_valid8, 0);
        check("rst_idx", out_idx8, 0);
        check("rst_last", out_last8, 0);
        check("rst_zero", out_zero8, 0);
        check("rst_ready", in_ready8, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Table vectors with out_ready held high.
        for (int i = 0; i < 6; i++) begin
            run_word8(table_v[i].data, 0, beats, first);
            check("tbl_beats", beats, table_v[i].beats);
            check("tbl_first", first, table_v[i].first_idx);
        end

        // 8'hff with out_ready toggling 1,0,0,...
        run_word8(8'hff, 1, beats, first);
        check("ff_stall_beats", beats, 8);

        // Back-to-back: 8'h80 then 8'h01 with in_valid held.
        @(posedge clk); #1;
        out_ready8 = 1'b1;
        in_valid8  = 1'b1;
        in_data8   = 8'h80;
        @(posedge clk); #1;
        in_data8 = 8'h01;
        @(negedge clk);
        check("b2b_idx7", out_idx8, 7);
        check("b2b_last7", out_last8, 1);
        check("b2b_ready", in_ready8, 1);
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        @(negedge clk);
        check("b2b_valid0", out_valid8, 1);
        check("b2b_idx0", out_idx8, 0);
        check("b2b_last0", out_last8, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("b2b_idle", out_valid8, 0);

        // WIDTH=16, LSB first: 16'h8001, stall on the first beat.
        @(posedge clk); #1;
        in_valid16  = 1'b1;
        in_data16   = 16'h8001;
        out_ready16 = 1'b0;
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("w16_stall_idx", out_idx16, 0);
            check("w16_stall_last", out_last16, 0);
            check("w16_stall_ready", in_ready16, 0);
            @(posedge clk); #1;
        end
        out_ready16 = 1'b1;
        @(negedge clk);
        check("w16_idx0", out_idx16, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("w16_idx15", out_idx16, 15);
        check("w16_last15", out_last16, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("w16_idle", out_valid16, 0);

        // Reset after the first beat of 8'h0f.
        @(posedge clk); #1;
        in_valid8 = 1'b1;
        in_data8  = 8'h0f;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        @(negedge clk);
        check("rst_mid_idx3", out_idx8, 3);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", out_valid8, 0);
        check("rst_mid_last", out_last8, 0);
        check("rst_mid_ready", in_ready8, 1);
        @(negedge clk);
        rst_n = 1'b1;
        run_word8(8'h02, 0, beats, first);
        check("post_rst_beats", beats, 1);
        check("post_rst_idx", first, 1);

        // Random words with random backpressure.
        for (int n = 0; n < 40; n++) begin
            logic [7:0] w;
            w = 8'($urandom) & 8'($urandom);
            if (n % 8 == 0) w = 8'h00;
            run_word8(w, 2, beats, first);
            check("rnd_beats", beats, (w == 0) ? 1 : $countones(w));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
